// File: rtl/bus_initiator.sv
// -----------------------------------------------------------------------------
// bus_initiator
//   Peripheral-bus master. Accepts single read/write commands from an internal
//   requester and runs exactly one bus access per command, returning read data
//   and a timeout flag on a one-cycle response pulse.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rest         in   asynchronous active-high reset
//   cmd_valid    in   command request
//   cmd_ready    out  high in IDLE (and out of reset); accept = valid & ready
//   cmd_rw       in   READ (1) / WRITE (0)
//   cmd_addr     in   target register address
//   cmd_wdata    in   write data (ignored for reads)
//   rsp_valid    out  one-cycle response pulse
//   rsp_rdata    out  read data; 0 for writes and timeouts
//   rsp_err      out  timeout flag
//   bus_cs       out  chip select
//   bus_as       out  address strobe
//   bus_rw       out  READ / WRITE
//   bus_addr     out  bus address
//   bus_wr_data  out  bus write data
//   bus_rdy      in   slave ready
//   bus_rd_data  in   slave read data, sampled when bus_rdy=1
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a command; bus idle
// S_STROBE | one cycle with cs+as; a combinational-rdy slave may answer
// S_WAIT   | cs held, as low; wait for rdy or timeout
// S_RESP   | one-cycle response pulse, bus released
// -----------------------------------------------------------------------------
module bus_initiator #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bus_cs,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_rd_data
);

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Last WAIT count value before giving up.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       done;

  assign accept = cmd_valid & cmd_ready;
  // True on the edge that leaves STROBE/WAIT toward RESP.
  assign done   = (state != S_RESP) && (state_nxt == S_RESP);

  // State register
  always_ff @(posedge clk or posedge rest) begin
    if (rest) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_STROBE;
      S_STROBE: state_nxt = bus_rdy ? S_RESP : S_WAIT;
      S_WAIT:   if (bus_rdy || (wait_cnt == TO_LAST)) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state. cmd_ready is also gated by reset so the
  // requester cannot hand over a command that would be lost.
  always_comb begin
    cmd_ready = 1'b0;
    bus_cs    = 1'b0;
    bus_as    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE:   cmd_ready = ~rest;
      S_STROBE: begin
        bus_cs = 1'b1;
        bus_as = 1'b1;
      end
      S_WAIT:   bus_cs = 1'b1;
      S_RESP:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Bus address/control/data hold from one accept to the next.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
    end else if (accept) begin
      bus_rw      <= cmd_rw;
      bus_addr    <= cmd_addr;
      bus_wr_data <= cmd_wdata;
    end
  end

  // Cleared outside WAIT so every WAIT entry starts from zero. The last
  // increment (on the exit edge) is harmless since the count is cleared
  // again in RESP.
  always_ff @(posedge clk or posedge rest) begin
    if (rest)                 wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
    else                      wait_cnt <= '0;
  end

  // Response capture; rdy beats a coincident timeout.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (done) begin
      if (bus_rdy) begin
        rsp_rdata <= (bus_rw == READ) ? bus_rd_data : '0;
        rsp_err   <= 1'b0;
      end else begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
`timescale 1ns/1ps
module tb_bus_initiator;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic          clk = 1'b0;
  logic          rest;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          bus_cs;
  logic          bus_as;
  logic          bus_rw;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic          bus_rdy;
  logic [DW-1:0] bus_rd_data;

  bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rest        (rest),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .bus_cs      (bus_cs),
    .bus_as      (bus_as),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rdy     (bus_rdy),
    .bus_rd_data (bus_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          rsp_cyc;
  } rsp_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] wdata;
    int          acc;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];
  bus_t cur;

  int n_cmp = 0;
  int n_bad = 0;
  int rsp_cnt = 0;
  int n_expect = 0;
  int since = 0;
  bit active = 0;
  bit inject = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor + responder, everything on the falling edge.
  always @(negedge clk) begin
    rsp_t e;
    if (rest) begin
      active      = 0;
      bus_rdy     = 1'b0;
      bus_rd_data = '0;
    end else begin
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) check_val("spurious_rsp", 1, 0);
        else begin
          e = rsp_q.pop_front();
          check_val("rsp_cyc", 32'(cyc), 32'(e.rsp_cyc));
          check_val("rsp_rdata", rsp_rdata, e.rdata);
          check_val("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
      if (bus_as) begin
        if (bus_q.size() == 0) check_val("spurious_as", 1, 0);
        else begin
          cur    = bus_q.pop_front();
          active = 1;
          since  = 0;
          check_val("as_cyc", 32'(cyc), 32'(cur.acc + 1));
          check_val("bus_rw", {31'd0, bus_rw}, {31'd0, cur.rw});
          check_val("bus_addr", {29'd0, bus_addr}, {29'd0, cur.addr});
          if (cur.rw == WR) check_val("bus_wdata", bus_wr_data, cur.wdata);
        end
      end else if (active && bus_cs) begin
        since++;
      end else begin
        active = 0;
      end
      bus_rdy     = (active && bus_cs && since == cur.delay) || inject;
      bus_rd_data = bus_rdy ? cur.rdata : (32'hBAD0_0000 | 32'(cyc));
    end
  end

  // Drive a command starting at posedge+1; returns at posedge+1 after the
  // accept edge with cmd_valid still high.
  task automatic issue(input logic rw, input logic [2:0] addr, input logic [31:0] wdata,
                       input int delay, input logic [31:0] rdata, output int acc);
    bus_t b;
    rsp_t r;
    bit   got = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    acc = -1;
    if (!got) check_val("accept_timeout", 0, 1);
    else begin
      acc = cyc;
      b = '{delay, rdata, rw, addr, wdata, acc};
      bus_q.push_back(b);
      r.err     = (delay > TO);
      r.rdata   = (r.err || rw == WR) ? 32'd0 : rdata;
      r.rsp_cyc = acc + 2 + ((delay > TO) ? TO : delay);
      rsp_q.push_back(r);
      n_expect++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0) ok = 1;
    end
    if (!ok) check_val("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int a;
    int a2;
    rest      = 1'b1;
    cmd_valid = 1'b0;
    cmd_rw    = RD;
    cmd_addr  = '0;
    cmd_wdata = '0;
    bus_rdy   = 1'b0;
    bus_rd_data = '0;

    repeat (3) @(negedge clk);
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    check_val("rst_cs_as", {30'd0, bus_cs, bus_as}, 0);
    check_val("rst_bus_rw", {31'd0, bus_rw}, {31'd0, RD});
    check_val("rst_bus_addr", {29'd0, bus_addr}, 0);
    check_val("rst_bus_wdata", bus_wr_data, 0);
    check_val("rst_rsp", {30'd0, rsp_valid, rsp_err}, 0);
    check_val("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    rest = 1'b0;

    // 1: read with registered-rdy slave; cmd changes while busy are ignored
    issue(RD, 3'h2, 32'h0, 1, 32'h0000_0005, a);
    cmd_valid = 1'b0;
    cmd_addr  = 3'h7;
    cmd_rw    = WR;
    drain();

    // 2: write; responder drives junk read data that must not appear
    issue(WR, 3'h0, 32'h0000_0005, 1, 32'hFFFF_FFFF, a);
    cmd_valid = 1'b0;
    drain();

    // 3: no rdy -> timeout, then a late rdy must not create a second response
    issue(RD, 3'h1, 32'h0, 1000, 32'h1234_5678, a);
    cmd_valid = 1'b0;
    drain();
    inject = 1;
    @(posedge clk); #1;
    inject = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("late_rdy_rsp_cnt", 32'(rsp_cnt), 32'(n_expect));

    // 4: rdy in the last WAIT cycle wins; comb rdy in STROBE; one-past timeout
    issue(RD, 3'h3, 32'h0, 15, 32'hCAFE_0015, a);
    cmd_valid = 1'b0;
    drain();
    issue(RD, 3'h4, 32'h0, 0, 32'h0000_00A5, a);
    cmd_valid = 1'b0;
    drain();
    issue(RD, 3'h5, 32'h0, 16, 32'h0000_0016, a);
    cmd_valid = 1'b0;
    drain();

    // 5: back-to-back reads with cmd_valid held high
    issue(RD, 3'h1, 32'h0, 1, 32'h0000_0011, a);
    issue(RD, 3'h2, 32'h0, 1, 32'h0000_0022, a2);
    cmd_valid = 1'b0;
    check_val("b2b_accept_gap", 32'(a2 - a), 32'd4);
    drain();

    // 6: reset during WAIT drops the transaction
    issue(RD, 3'h5, 32'h0, 1000, 32'h0000_0066, a);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("pre_rst_cs", {31'd0, bus_cs}, 1);
    rest = 1'b1;
    #1;
    check_val("mid_rst_cs_as", {30'd0, bus_cs, bus_as}, 0);
    check_val("mid_rst_ready", {31'd0, cmd_ready}, 0);
    rsp_q.delete();
    bus_q.delete();
    n_expect--;
    bus_rdy = 1'b0;
    @(posedge clk); #1;
    rest = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", {31'd0, cmd_ready}, 1);
    @(posedge clk); #1;
    issue(RD, 3'h6, 32'h0, 2, 32'h0000_0077, a);
    cmd_valid = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    #1;

    check_val("sb_empty", 32'(rsp_q.size()), 0);
    check_val("rsp_count", 32'(rsp_cnt), 32'(n_expect));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
